atm_session_ctrl: RTL and testbench
===================================

# atm_session_ctrl

Transaction sequencer and owner of the on-chip card database for the ATM system. It accepts card enrolment and card-insert requests, scans the card table, runs PIN authentication with a retry limit, and executes balance, withdraw and deposit operations. Each operation is answered with a one-cycle response carrying a status code and a balance. It sits between the user-facing I/O front end and the card/PIN/balance storage, and is the only writer of that storage.

## Interface
- N, default `Number (8 if undefined): number of card table entries.
- CARD_W, 10: card number width.
- PIN_W, 11: PIN width.
- BAL_W, 11: balance and amount width.
- MAX_TRIES, 3: wrong-PIN attempts allowed per session.
- INIT_BAL, 500: balance of a newly enrolled card.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  card insert; sampled in IDLE.
- add_req  in  1  enrol the card on card_in with the PIN on pin_in; sampled in IDLE.
- card_in  in  CARD_W  card number.
- pin_valid  in  1  PIN entry strobe.
- pin_in  in  PIN_W  PIN.
- op_valid  in  1  operation strobe.
- op  in  2  operation: 00 balance, 01 withdraw, 10 deposit, 11 exit.
- amount  in  BAL_W  withdraw or deposit amount.
- busy  out  1  high whenever the state is not IDLE.
- pin_ready  out  1  high in WAIT_PIN.
- op_ready  out  1  high in WAIT_OP.
- resp_valid  out  1  one-cycle response pulse.
- status  out  3  response code: 0 OK, 1 NO_CARD, 2 BAD_PIN, 3 LOCKED, 4 INSUFF, 5 OVERFLOW, 6 EXISTS, 7 FULL.
- balance_out  out  BAL_W  balance of the session card; 0 when there is no session card.
- card_count  out  $clog2(N+1)  number of enrolled cards.

## Operation
- States: IDLE, SEARCH, WAIT_PIN, CHECK_PIN, WAIT_OP, EXEC, WRITE, RESP.
- IDLE
  - start moves to SEARCH in session mode.
  - add_req moves to SEARCH in enrol mode.
  - If start and add_req are both high, start wins and add_req is dropped.
  - card_in and pin_in are latched on acceptance.
- SEARCH
  - Compares entry idx = 0..N-1, one entry per cycle, against valid entries only.
  - Session mode, hit: session index is stored, state goes to WAIT_PIN and tries = 0.
  - Session mode, hit on a locked entry: LOCKED.
  - Session mode, miss: NO_CARD.
  - Enrol mode, hit: EXISTS.
  - Enrol mode, miss with card_count == N: FULL.
  - Enrol mode, miss otherwise: WRITE.
- WRITE
  - Writes slot card_count with {card, pin, INIT_BAL} and sets its valid bit.
  - card_count increments; response is OK.
- WAIT_PIN: pin_valid moves to CHECK_PIN.
- CHECK_PIN
  - PIN match goes to WAIT_OP with no response pulse.
  - Mismatch increments tries and responds BAD_PIN.
  - If tries < MAX_TRIES, the state returns to WAIT_PIN after RESP; otherwise the session ends.
- WAIT_OP: op_valid moves to EXEC.
- EXEC
  - balance: responds OK.
  - withdraw: if amount > balance, INSUFF with balance unchanged; else balance -= amount, OK.
  - deposit: computed on BAL_W+1 bits. If the sum exceeds 2^BAL_W-1, OVERFLOW with balance unchanged; else OK.
  - amount 0 is legal and returns OK.
  - exit: responds OK and ends the session.
- RESP
  - Drives resp_valid for one cycle.
  - Continues to WAIT_OP if the session is alive, WAIT_PIN on a retry, otherwise IDLE.
- Entries are never deleted.
- Strobes arriving in non-accepting states are ignored.

## Timing
- Reset
  - All outputs 0, state IDLE, every valid bit and lock bit cleared, card_count 0.
  - Reset mid-operation aborts that operation with no response.
- start accepted in cycle t:
  - Entry i is compared in cycle t+1+i.
  - A hit raises pin_ready at t+2+i.
  - A session-mode miss gives resp_valid at t+N+2.
- Enrol miss: WRITE at t+N+1, resp_valid at t+N+2, and card_count is updated in the same cycle as resp_valid.
- pin_valid at cycle p: op_ready at p+2, or BAD_PIN resp_valid at p+2.
- op_valid at cycle q: resp_valid at q+2, and balance_out shows the post-operation value in the same cycle.
- A strobe held high for several cycles is consumed once per accepting-state entry.

## Configuration
- LOCKOUT_EN defined
  - Reaching MAX_TRIES sets the entry's persistent lock bit and responds LOCKED instead of BAD_PIN.
  - Later inserts of that card respond LOCKED without a PIN prompt.
  - Only rst clears lock bits.
- LOCKOUT_EN undefined
  - No lock bits exist.
  - Exhausting tries responds BAD_PIN and returns to IDLE.
  - The card remains usable on the next insert.

## Structure
- Shared package atm_pkg holds:
  - status codes;
  - op encodings;
  - state enum;
  - default widths;
  - INIT_BAL.
- Sub-module card_table:
  - per-entry card, pin, balance, valid and (with LOCKOUT_EN) lock registers;
  - one combinational read port indexed by the controller;
  - one synchronous write port for enrol and balance update.
- The controller FSM, idx counter, tries counter and arithmetic stay in atm_session_ctrl.

## Test plan
- Enrol card 10'b0000000101 with PIN 11'd1234 → resp OK at t+N+2, card_count 1. Repeat the same request → EXISTS.
- Insert that card, PIN 1234, withdraw 200 → OK with balance_out 300. Then withdraw 301 → INSUFF with balance_out 300.
- Deposit 1747 on balance 300 → OK with balance_out 2047. Then deposit 1 → OVERFLOW with balance_out 2047.
- Three wrong PINs (MAX_TRIES 3):
  - Each attempt → BAD_PIN.
  - The third → LOCKED with LOCKOUT_EN; a reinsert → LOCKED within N+2 cycles.
  - Without the macro the third → BAD_PIN and a reinsert prompts for the PIN.
- Enrol N distinct cards, then an (N+1)th → FULL. Insert an unknown card → NO_CARD at t+N+2.
- start and add_req high together → session path only, card_count unchanged. Then assert rst during SEARCH → no resp_valid, busy 0 and card_count 0 on the next cycle.

Source files
------------

// File: rtl/atm_pkg.sv
// atm_pkg: shared status/op encodings, FSM states and default sizes for the ATM controller.
// The table depth defaults to the `Number macro, or 8 when it is not defined.
`ifndef Number
`define Number 8
`endif

package atm_pkg;

   localparam int DEF_N         = `Number;
   localparam int DEF_CARD_W    = 10;
   localparam int DEF_PIN_W     = 11;
   localparam int DEF_BAL_W     = 11;
   localparam int DEF_MAX_TRIES = 3;
   localparam int DEF_INIT_BAL  = 500;

   typedef enum logic [2:0] {
      ST_OK       = 3'd0,
      ST_NO_CARD  = 3'd1,
      ST_BAD_PIN  = 3'd2,
      ST_LOCKED   = 3'd3,
      ST_INSUFF   = 3'd4,
      ST_OVERFLOW = 3'd5,
      ST_EXISTS   = 3'd6,
      ST_FULL     = 3'd7
   } status_e;

   typedef enum logic [1:0] {
      OP_BAL      = 2'd0,
      OP_WITHDRAW = 2'd1,
      OP_DEPOSIT  = 2'd2,
      OP_EXIT     = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      IDLE, SEARCH, WAIT_PIN, CHECK_PIN, WAIT_OP, EXEC, WRITE, RESP
   } state_e;

endpackage

// File: rtl/card_table.sv
// card_table: per-entry card/PIN/balance storage with one combinational read port and
// one synchronous write port. Persistent lock bits exist only when LOCKOUT_EN is defined.
module card_table
   import atm_pkg::*;
#(
   parameter int N      = DEF_N,
   parameter int CARD_W = DEF_CARD_W,
   parameter int PIN_W  = DEF_PIN_W,
   parameter int BAL_W  = DEF_BAL_W,
   parameter int IW     = $clog2(N + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IW-1:0]     rd_idx,
   output logic              rd_valid,
   output logic              rd_lock,
   output logic [CARD_W-1:0] rd_card,
   output logic [PIN_W-1:0]  rd_pin,
   output logic [BAL_W-1:0]  rd_bal,
   input  logic              wr_en,
   input  logic              wr_enrol,
   input  logic [IW-1:0]     wr_idx,
   input  logic [CARD_W-1:0] wr_card,
   input  logic [PIN_W-1:0]  wr_pin,
   input  logic [BAL_W-1:0]  wr_bal,
   input  logic              lock_set
);

   localparam int AW = (N > 1) ? $clog2(N) : 1;

   logic [CARD_W-1:0] card_mem [N];
   logic [PIN_W-1:0]  pin_mem  [N];
   logic [BAL_W-1:0]  bal_mem  [N];
   logic [N-1:0]      valid_r;
   logic [AW-1:0]     rd_a;
   logic [AW-1:0]     wr_a;
   logic              rd_ok;
   logic              unused_bits;

   // The controller scans one index past the table end, which must read as empty.
   assign rd_a     = rd_idx[AW-1:0];
   assign wr_a     = wr_idx[AW-1:0];
   assign rd_ok    = (rd_idx < IW'(N));
   assign rd_valid = rd_ok & valid_r[rd_a];
   assign rd_card  = card_mem[rd_a];
   assign rd_pin   = pin_mem[rd_a];
   assign rd_bal   = bal_mem[rd_a];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         bal_mem[wr_a] <= wr_bal;
         if (wr_enrol) begin
            card_mem[wr_a] <= wr_card;
            pin_mem[wr_a]  <= wr_pin;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= '0;
      end else if (wr_en && wr_enrol) begin
         valid_r[wr_a] <= 1'b1;
      end
   end

`ifdef LOCKOUT_EN
   logic [N-1:0] lock_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_r <= '0;
      end else if (lock_set) begin
         lock_r[wr_a] <= 1'b1;
      end
   end

   assign rd_lock = rd_ok & lock_r[rd_a];
`else
   assign rd_lock = 1'b0;
`endif

   assign unused_bits = ^{wr_idx, lock_set};

endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: enrolment/session sequencer, PIN retry logic and balance arithmetic.
// Optional macro LOCKOUT_EN makes exhausting the PIN retries lock the card until reset.
module atm_session_ctrl
   import atm_pkg::*;
#(
   parameter int N         = DEF_N,
   parameter int CARD_W    = DEF_CARD_W,
   parameter int PIN_W     = DEF_PIN_W,
   parameter int BAL_W     = DEF_BAL_W,
   parameter int MAX_TRIES = DEF_MAX_TRIES,
   parameter int INIT_BAL  = DEF_INIT_BAL
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     add_req,
   input  logic [CARD_W-1:0]        card_in,
   input  logic                     pin_valid,
   input  logic [PIN_W-1:0]         pin_in,
   input  logic                     op_valid,
   input  logic [1:0]               op,
   input  logic [BAL_W-1:0]         amount,
   output logic                     busy,
   output logic                     pin_ready,
   output logic                     op_ready,
   output logic                     resp_valid,
   output logic [2:0]               status,
   output logic [BAL_W-1:0]         balance_out,
   output logic [$clog2(N+1)-1:0]   card_count
);

   localparam int IW = $clog2(N + 1);
   localparam int TW = $clog2(MAX_TRIES + 1);

   state_e            state, state_nx, after_q, after_nx;
   status_e           status_q, status_nx;
   op_e               op_q, op_nx;
   logic              enrol_q, enrol_nx, have_card, have_nx;
   logic [CARD_W-1:0] card_q, card_nx;
   logic [PIN_W-1:0]  pin_q, pin_nx;
   logic [BAL_W-1:0]  amt_q, amt_nx;
   logic [IW-1:0]     idx, idx_nx, sess_idx, sess_nx, count, count_nx;
   logic [TW-1:0]     tries, tries_nx;

   logic              rd_valid, rd_lock, wr_en, wr_enrol, lock_set;
   logic [CARD_W-1:0] rd_card;
   logic [PIN_W-1:0]  rd_pin;
   logic [BAL_W-1:0]  rd_bal, wr_bal;
   logic [IW-1:0]     rd_idx, wr_idx;
   logic [BAL_W:0]    dep_sum;

   assign rd_idx  = (state == SEARCH) ? idx : sess_idx;
   assign wr_idx  = (state == WRITE) ? count : sess_idx;
   assign dep_sum = {1'b0, rd_bal} + {1'b0, amt_q};

   card_table #(
      .N(N), .CARD_W(CARD_W), .PIN_W(PIN_W), .BAL_W(BAL_W), .IW(IW)
   ) u_table (
      .clk(clk), .rst(rst),
      .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_lock(rd_lock),
      .rd_card(rd_card), .rd_pin(rd_pin), .rd_bal(rd_bal),
      .wr_en(wr_en), .wr_enrol(wr_enrol), .wr_idx(wr_idx),
      .wr_card(card_q), .wr_pin(pin_q), .wr_bal(wr_bal), .lock_set(lock_set)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         after_q   <= IDLE;
         status_q  <= ST_OK;
         op_q      <= OP_BAL;
         enrol_q   <= 1'b0;
         have_card <= 1'b0;
         card_q    <= '0;
         pin_q     <= '0;
         amt_q     <= '0;
         idx       <= '0;
         sess_idx  <= '0;
         count     <= '0;
         tries     <= '0;
      end else begin
         state     <= state_nx;
         after_q   <= after_nx;
         status_q  <= status_nx;
         op_q      <= op_nx;
         enrol_q   <= enrol_nx;
         have_card <= have_nx;
         card_q    <= card_nx;
         pin_q     <= pin_nx;
         amt_q     <= amt_nx;
         idx       <= idx_nx;
         sess_idx  <= sess_nx;
         count     <= count_nx;
         tries     <= tries_nx;
      end
   end

   // A session miss scans one extra slot (idx == N) so it answers in the same cycle
   // an enrol miss does after passing through WRITE.
   always_comb begin
      state_nx  = state;
      after_nx  = after_q;
      status_nx = status_q;
      op_nx     = op_q;
      enrol_nx  = enrol_q;
      have_nx   = have_card;
      card_nx   = card_q;
      pin_nx    = pin_q;
      amt_nx    = amt_q;
      idx_nx    = idx;
      sess_nx   = sess_idx;
      count_nx  = count;
      tries_nx  = tries;
      wr_en     = 1'b0;
      wr_enrol  = 1'b0;
      wr_bal    = rd_bal;
      lock_set  = 1'b0;
      case (state)
         IDLE: begin
            if (start || add_req) begin
               state_nx = SEARCH;
               enrol_nx = !start;
               card_nx  = card_in;
               pin_nx   = pin_in;
               idx_nx   = '0;
            end
         end
         SEARCH: begin
            if (idx == IW'(N)) begin
               state_nx  = RESP;
               after_nx  = IDLE;
               status_nx = enrol_q ? ST_FULL : ST_NO_CARD;
            end else if (rd_valid && (rd_card == card_q)) begin
               state_nx = RESP;
               after_nx = IDLE;
               if (enrol_q) begin
                  status_nx = ST_EXISTS;
               end else if (rd_lock) begin
                  status_nx = ST_LOCKED;
               end else begin
                  state_nx = WAIT_PIN;
                  sess_nx  = idx;
                  have_nx  = 1'b1;
                  tries_nx = '0;
               end
            end else if (enrol_q && (idx == IW'(N - 1)) && (count != IW'(N))) begin
               state_nx = WRITE;
            end else begin
               idx_nx = idx + IW'(1);
            end
         end
         WRITE: begin
            wr_en     = 1'b1;
            wr_enrol  = 1'b1;
            wr_bal    = BAL_W'(INIT_BAL);
            count_nx  = count + IW'(1);
            status_nx = ST_OK;
            after_nx  = IDLE;
            state_nx  = RESP;
         end
         WAIT_PIN: begin
            if (pin_valid) begin
               pin_nx   = pin_in;
               state_nx = CHECK_PIN;
            end
         end
         CHECK_PIN: begin
            if (rd_pin == pin_q) begin
               state_nx = WAIT_OP;
            end else begin
               tries_nx  = tries + TW'(1);
               state_nx  = RESP;
               status_nx = ST_BAD_PIN;
               if ((tries + TW'(1)) < TW'(MAX_TRIES)) begin
                  after_nx = WAIT_PIN;
               end else begin
                  after_nx = IDLE;
`ifdef LOCKOUT_EN
                  status_nx = ST_LOCKED;
                  lock_set  = 1'b1;
`endif
               end
            end
         end
         WAIT_OP: begin
            if (op_valid) begin
               op_nx    = op_e'(op);
               amt_nx   = amount;
               state_nx = EXEC;
            end
         end
         EXEC: begin
            state_nx  = RESP;
            after_nx  = WAIT_OP;
            status_nx = ST_OK;
            case (op_q)
               OP_WITHDRAW: begin
                  if (amt_q > rd_bal) begin
                     status_nx = ST_INSUFF;
                  end else begin
                     wr_en  = 1'b1;
                     wr_bal = rd_bal - amt_q;
                  end
               end
               OP_DEPOSIT: begin
                  if (dep_sum[BAL_W]) begin
                     status_nx = ST_OVERFLOW;
                  end else begin
                     wr_en  = 1'b1;
                     wr_bal = dep_sum[BAL_W-1:0];
                  end
               end
               OP_EXIT: after_nx = IDLE;
               default: ;
            endcase
         end
         RESP: begin
            state_nx = after_q;
            if (after_q == IDLE) begin
               have_nx = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy        = (state != IDLE);
   assign pin_ready   = (state == WAIT_PIN);
   assign op_ready    = (state == WAIT_OP);
   assign resp_valid  = (state == RESP);
   assign status      = resp_valid ? status_q : ST_OK;
   assign balance_out = have_card ? rd_bal : '0;
   assign card_count  = count;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: scoreboarded bench for the ATM controller; a table of operations
// plus hand-written enrol, PIN retry, table-full and reset sequences.
`ifndef Number
`define Number 8
`endif

module tb_atm_session_ctrl;

   localparam int N  = `Number;
   localparam int CW = $clog2(N + 1);

   localparam int S_OK = 0, S_NO_CARD = 1, S_BAD_PIN = 2, S_LOCKED = 3;
   localparam int S_INSUFF = 4, S_OVERFLOW = 5, S_EXISTS = 6, S_FULL = 7;
   localparam logic [1:0] OP_BAL = 2'd0, OP_WD = 2'd1, OP_DEP = 2'd2, OP_EXIT = 2'd3;

`ifdef LOCKOUT_EN
   localparam int LAST_TRY_ST = S_LOCKED;
`else
   localparam int LAST_TRY_ST = S_BAD_PIN;
`endif

   typedef struct {
      string name;
      int    st;
      int    bal;
      bit    chk_bal;
   } exp_t;

   typedef struct {
      logic [1:0] op;
      int         amt;
      int         st;
      int         bal;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, add_req, pin_valid, op_valid;
   logic [9:0]    card_in;
   logic [10:0]   pin_in;
   logic [1:0]    op;
   logic [10:0]   amount;
   logic          busy, pin_ready, op_ready, resp_valid;
   logic [2:0]    status;
   logic [10:0]   balance_out;
   logic [CW-1:0] card_count;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   resp_seen = 0;
   int   last_resp_cyc = 0;
   exp_t exp_q[$];
   vec_t vecs[$];

   atm_session_ctrl #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .add_req(add_req), .card_in(card_in),
      .pin_valid(pin_valid), .pin_in(pin_in), .op_valid(op_valid), .op(op),
      .amount(amount), .busy(busy), .pin_ready(pin_ready), .op_ready(op_ready),
      .resp_valid(resp_valid), .status(status), .balance_out(balance_out),
      .card_count(card_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Every response pulse is matched against the oldest queued expectation.
   always @(negedge clk) begin
      if (resp_valid === 1'b1) begin
         exp_t e;
         resp_seen++;
         last_resp_cyc = cyc;
         if (exp_q.size() == 0) begin
            check("unexpected_resp", int'(resp_valid), 0);
         end else begin
            e = exp_q.pop_front();
            check({e.name, "_status"}, int'(status), e.st);
            if (e.chk_bal) check({e.name, "_balance"}, int'(balance_out), e.bal);
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_resp(input string name, input int st, input int bal, input bit chk_bal);
      exp_t e;
      e.name    = name;
      e.st      = st;
      e.bal     = bal;
      e.chk_bal = chk_bal;
      exp_q.push_back(e);
   endtask

   task automatic wait_resp(input string name, input int t0, input int lat);
      int n0;
      int k;
      n0 = resp_seen;
      k  = 0;
      while (resp_seen == n0 && k < lat + 4) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (resp_seen == n0) check({name, "_timeout"}, resp_seen - n0, 1);
      else check({name, "_latency"}, last_resp_cyc - t0, lat);
   endtask

   task automatic apply_stimulus(input logic s, input logic a, input logic [9:0] card,
                                 input logic [10:0] pin, output int t0);
      tick();
      start   = s;
      add_req = a;
      card_in = card;
      pin_in  = pin;
      t0      = cyc;
      tick();
      start   = 1'b0;
      add_req = 1'b0;
   endtask

   task automatic enrol(input string name, input logic [9:0] card, input logic [10:0] pin,
                        input int st, input int lat);
      int t0;
      expect_resp(name, st, 0, 1'b1);
      apply_stimulus(1'b0, 1'b1, card, pin, t0);
      wait_resp(name, t0, lat);
   endtask

   task automatic insert(input string name, input logic [9:0] card, input int entry);
      int t0;
      apply_stimulus(1'b1, 1'b0, card, 11'd0, t0);
      @(negedge clk);
      while (cyc < t0 + 1 + entry) @(negedge clk);
      check({name, "_early_prompt"}, int'(pin_ready), 0);
      @(negedge clk);
      check({name, "_pin_ready"}, int'(pin_ready), 1);
   endtask

   task automatic enter_pin(input string name, input logic [10:0] pin, input bit ok,
                            input int st, input int bal);
      int p;
      if (!ok) expect_resp(name, st, bal, 1'b1);
      tick();
      pin_valid = 1'b1;
      pin_in    = pin;
      p         = cyc;
      tick();
      pin_valid = 1'b0;
      if (ok) begin
         @(negedge clk);
         @(negedge clk);
         check({name, "_op_ready"}, int'(op_ready), 1);
      end else begin
         wait_resp(name, p, 2);
      end
   endtask

   task automatic check_output(input string name, input logic [1:0] o, input int amt,
                               input int st, input int bal, input bit chk_bal);
      int q;
      expect_resp(name, st, bal, chk_bal);
      tick();
      op_valid = 1'b1;
      op       = o;
      amount   = 11'(amt);
      q        = cyc;
      tick();
      op_valid = 1'b0;
      wait_resp(name, q, 2);
   endtask

   initial begin
      int t0;
      int cur_bal;

      rst = 1'b1; start = 1'b0; add_req = 1'b0; pin_valid = 1'b0; op_valid = 1'b0;
      card_in = '0; pin_in = '0; op = '0; amount = '0;

      vecs.push_back('{OP_BAL, 0,    S_OK,       500});
      vecs.push_back('{OP_WD,  200,  S_OK,       300});
      vecs.push_back('{OP_WD,  301,  S_INSUFF,   300});
      vecs.push_back('{OP_WD,  0,    S_OK,       300});
      vecs.push_back('{OP_DEP, 1747, S_OK,       2047});
      vecs.push_back('{OP_DEP, 1,    S_OVERFLOW, 2047});
      vecs.push_back('{OP_DEP, 0,    S_OK,       2047});
      vecs.push_back('{OP_WD,  2047, S_OK,       0});
      vecs.push_back('{OP_WD,  1,    S_INSUFF,   0});
      vecs.push_back('{OP_DEP, 2047, S_OK,       2047});
      vecs.push_back('{OP_WD,  47,   S_OK,       2000});
      vecs.push_back('{OP_DEP, 48,   S_OVERFLOW, 2000});
      vecs.push_back('{OP_DEP, 47,   S_OK,       2047});

      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_pin_ready", int'(pin_ready), 0);
      check("rst_op_ready", int'(op_ready), 0);
      check("rst_resp_valid", int'(resp_valid), 0);
      check("rst_status", int'(status), 0);
      check("rst_balance", int'(balance_out), 0);
      check("rst_card_count", int'(card_count), 0);

      enrol("enrol_first", 10'd5, 11'd1234, S_OK, N + 2);
      check("enrol_first_count", int'(card_count), 1);
      enrol("enrol_dup", 10'd5, 11'd999, S_EXISTS, 2);
      check("enrol_dup_count", int'(card_count), 1);

      insert("insert_a", 10'd5, 0);
      enter_pin("pin_a", 11'd1234, 1'b1, 0, 0);
      cur_bal = 500;
      for (int i = 0; i < vecs.size(); i++) begin
         check_output($sformatf("vec%0d", i), vecs[i].op, vecs[i].amt, vecs[i].st, vecs[i].bal, 1'b1);
         cur_bal = vecs[i].bal;
      end
      check_output("exit_a", OP_EXIT, 0, S_OK, 0, 1'b0);
      tick();
      check("exit_a_busy", int'(busy), 0);
      check("exit_a_balance", int'(balance_out), 0);

      insert("insert_retry", 10'd5, 0);
      enter_pin("wrong1", 11'd1, 1'b0, S_BAD_PIN, cur_bal);
      check("wrong1_reprompt", int'(pin_ready), 0);
      tick();
      check("wrong1_pin_ready", int'(pin_ready), 1);
      enter_pin("wrong2", 11'd2, 1'b0, S_BAD_PIN, cur_bal);
      enter_pin("wrong3", 11'd3, 1'b0, LAST_TRY_ST, cur_bal);
      tick();
      check("wrong3_idle", int'(busy), 0);
`ifdef LOCKOUT_EN
      expect_resp("reinsert_locked", S_LOCKED, 0, 1'b1);
      apply_stimulus(1'b1, 1'b0, 10'd5, 11'd0, t0);
      wait_resp("reinsert_locked", t0, 2);
`else
      insert("reinsert_ok", 10'd5, 0);
      enter_pin("reinsert_pin", 11'd1234, 1'b1, 0, 0);
      check_output("reinsert_bal", OP_BAL, 0, S_OK, cur_bal, 1'b1);
      check_output("reinsert_exit", OP_EXIT, 0, S_OK, 0, 1'b0);
`endif

      expect_resp("both_strobes", S_NO_CARD, 0, 1'b1);
      apply_stimulus(1'b1, 1'b1, 10'd77, 11'd55, t0);
      wait_resp("both_strobes", t0, N + 2);
      check("both_strobes_count", int'(card_count), 1);

      for (int i = 1; i < N; i++) begin
         enrol($sformatf("fill%0d", i), 10'(100 + i), 11'(300 + i), S_OK, N + 2);
      end
      check("fill_count", int'(card_count), N);
      enrol("enrol_full", 10'd200, 11'd7, S_FULL, N + 2);
      check("full_count", int'(card_count), N);

      insert("insert_last", 10'(100 + N - 1), N - 1);
      enter_pin("pin_last", 11'(300 + N - 1), 1'b1, 0, 0);
      check_output("last_bal", OP_BAL, 0, S_OK, 500, 1'b1);
      check_output("last_exit", OP_EXIT, 0, S_OK, 0, 1'b0);

      expect_resp("unknown_card", S_NO_CARD, 0, 1'b1);
      apply_stimulus(1'b1, 1'b0, 10'd999, 11'd0, t0);
      wait_resp("unknown_card", t0, N + 2);

      apply_stimulus(1'b1, 1'b0, 10'd999, 11'd0, t0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_card_count", int'(card_count), 0);
      check("abort_resp_valid", int'(resp_valid), 0);
      repeat (N + 4) @(negedge clk);

      expect_resp("after_rst_lookup", S_NO_CARD, 0, 1'b1);
      apply_stimulus(1'b1, 1'b0, 10'd5, 11'd0, t0);
      wait_resp("after_rst_lookup", t0, N + 2);

      repeat (3) tick();
      check("scoreboard_drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
